// File: rtl/fifo_pkg.sv
// Shared helpers and default constants for the single-clock FIFO family.
package fifo_pkg;

    localparam int AFULL_MARGIN   = 4;
    localparam int AEMPTY_DEFAULT = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int fifo_depth(input int aw);
        return 1 << aw;
    endfunction

    function automatic int fifo_cnt_width(input int aw);
        return aw + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_sdpram.sv
// Distributed simple-dual-port array: synchronous write, registered read,
// optional second output stage.
module sync_fifo_sdpram
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8,
    parameter int OUT_REG    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] q1;
    logic                  v1;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Data holds between reads so rd_data stays stable while rd_valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            q1 <= '0;
            v1 <= 1'b0;
        end else begin
            v1 <= re;
            if (re) begin
                q1 <= mem[raddr];
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_WIDTH-1:0] q2;
            logic                  v2;

            always_ff @(posedge clk) begin
                if (rst) begin
                    q2 <= '0;
                    v2 <= 1'b0;
                end else begin
                    v2 <= v1;
                    if (v1) begin
                        q2 <= q1;
                    end
                end
            end

            assign rdata  = q2;
            assign rvalid = v2;
        end else begin : g_direct
            assign rdata  = q1;
            assign rvalid = v1;
        end
    endgenerate

endmodule

// File: rtl/sync_fifo_dist.sv
// Single-clock FIFO: pointers, occupancy, registered flags and sticky errors
// around a distributed SDP array.
module sync_fifo_dist
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH    = 10,
    parameter int DATA_WIDTH    = 8,
    parameter int OUT_REG       = 0,
    parameter int AFULL_THRESH  = (2 ** ADDR_WIDTH) - AFULL_MARGIN,
    parameter int AEMPTY_THRESH = AEMPTY_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   data_cnt,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int CW = fifo_cnt_width(ADDR_WIDTH);
    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AEMPTY_THRESH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]         cnt_next;
    logic                  wr_acc;
    logic                  rd_acc;

    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    always_comb begin
        cnt_next = data_cnt;
        unique case ({wr_acc, rd_acc})
            2'b10:   cnt_next = data_cnt + CNT_ONE;
            2'b01:   cnt_next = data_cnt - CNT_ONE;
            default: cnt_next = data_cnt;
        endcase
    end

    // Flags come from the next count so they move on the same edge as data_cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            data_cnt     <= '0;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            data_cnt     <= cnt_next;
            full         <= (cnt_next == DEPTH_C);
            almost_full  <= (cnt_next >= AF_C);
            empty        <= (cnt_next == '0);
            almost_empty <= (cnt_next <= AE_C);
            if (wr_en & full) begin
                overflow <= 1'b1;
            end
            if (rd_en & empty) begin
                underflow <= 1'b1;
            end
        end
    end

    sync_fifo_sdpram #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .OUT_REG   (OUT_REG)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .re    (rd_acc),
        .raddr (rd_ptr),
        .rdata (rd_data),
        .rvalid(rd_valid)
    );

endmodule

// File: tb/tb_sync_fifo_dist.sv
// Directed scoreboard bench for sync_fifo_dist, OUT_REG=0 and OUT_REG=1.
module tb_sync_fifo_dist;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en0 = 1'b0, rd_en0 = 1'b0;
    logic       wr_en1 = 1'b0, rd_en1 = 1'b0;
    logic [7:0] wr_data0 = '0, wr_data1 = '0;
    logic [7:0] rd_data0, rd_data1;
    logic       full0, afull0, rvld0, empty0, aempty0, ovf0, unf0;
    logic       full1, afull1, rvld1, empty1, aempty1, ovf1, unf1;
    logic [4:0] cnt0, cnt1;

    int total = 0;
    int bad   = 0;

    logic [7:0] mq[$];
    logic [7:0] exq[$];
    bit movf = 1'b0;
    bit munf = 1'b0;
    bit pend = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_dist #(
        .ADDR_WIDTH(4), .DATA_WIDTH(8), .OUT_REG(0),
        .AFULL_THRESH(12), .AEMPTY_THRESH(4)
    ) dut0 (
        .clk(clk), .rst(rst),
        .wr_en(wr_en0), .wr_data(wr_data0),
        .full(full0), .almost_full(afull0),
        .rd_en(rd_en0), .rd_data(rd_data0), .rd_valid(rvld0),
        .empty(empty0), .almost_empty(aempty0),
        .data_cnt(cnt0), .overflow(ovf0), .underflow(unf0)
    );

    sync_fifo_dist #(
        .ADDR_WIDTH(4), .DATA_WIDTH(8), .OUT_REG(1),
        .AFULL_THRESH(12), .AEMPTY_THRESH(4)
    ) dut1 (
        .clk(clk), .rst(rst),
        .wr_en(wr_en1), .wr_data(wr_data1),
        .full(full1), .almost_full(afull1),
        .rd_en(rd_en1), .rd_data(rd_data1), .rd_valid(rvld1),
        .empty(empty1), .almost_empty(aempty1),
        .data_cnt(cnt1), .overflow(ovf1), .underflow(unf1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input bit sel, input bit ev);
        logic       v, f, af, e, ae, ov, un;
        logic [7:0] d;
        logic [4:0] c;
        int         n;
        n = mq.size();
        if (sel) begin
            v = rvld1; d = rd_data1; c = cnt1; f = full1; af = afull1;
            e = empty1; ae = aempty1; ov = ovf1; un = unf1;
        end else begin
            v = rvld0; d = rd_data0; c = cnt0; f = full0; af = afull0;
            e = empty0; ae = aempty0; ov = ovf0; un = unf0;
        end
        chk("rd_valid", {31'b0, v}, {31'b0, ev});
        if (ev) begin
            if (exq.size() > 0) chk("rd_data", {24'b0, d}, {24'b0, exq.pop_front()});
            else chk("rd_valid_unexpected", {31'b0, v}, 32'd0);
        end
        chk("data_cnt", {27'b0, c}, n);
        chk("full", {31'b0, f}, {31'b0, n == 16});
        chk("almost_full", {31'b0, af}, {31'b0, n >= 12});
        chk("empty", {31'b0, e}, {31'b0, n == 0});
        chk("almost_empty", {31'b0, ae}, {31'b0, n <= 4});
        chk("overflow", {31'b0, ov}, {31'b0, movf});
        chk("underflow", {31'b0, un}, {31'b0, munf});
    endtask

    task automatic cyc(input bit sel, input bit wr, input logic [7:0] wd,
                       input bit rd);
        bit wacc, racc, ev;
        int n;
        n = mq.size();
        wacc = wr && (n < 16);
        racc = rd && (n > 0);
        if (wr && n == 16) movf = 1'b1;
        if (rd && n == 0) munf = 1'b1;
        if (racc) exq.push_back(mq.pop_front());
        if (wacc) mq.push_back(wd);
        ev = sel ? pend : racc;
        wr_en0 = sel ? 1'b0 : wr;
        rd_en0 = sel ? 1'b0 : rd;
        wr_data0 = wd;
        wr_en1 = sel ? wr : 1'b0;
        rd_en1 = sel ? rd : 1'b0;
        wr_data1 = wd;
        @(posedge clk);
        #1;
        check_outs(sel, ev);
        pend = racc;
    endtask

    task automatic do_reset(input bit sel, input bit rd);
        rst = 1'b1;
        wr_en0 = 1'b0;
        wr_en1 = 1'b0;
        rd_en0 = sel ? 1'b0 : rd;
        rd_en1 = sel ? rd : 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rd_en0 = 1'b0;
        rd_en1 = 1'b0;
        mq.delete();
        exq.delete();
        movf = 1'b0;
        munf = 1'b0;
        pend = 1'b0;
        check_outs(sel, 1'b0);
        chk("rd_data_rst", {24'b0, sel ? rd_data1 : rd_data0}, 32'd0);
    endtask

    initial begin
        do_reset(0, 0);

        for (int i = 0; i < 16; i++) cyc(0, 1, 8'(i), 0);
        for (int i = 0; i < 16; i++) cyc(0, 0, 8'h00, 1);
        cyc(0, 0, 8'h00, 0);

        for (int i = 0; i < 12; i++) cyc(0, 1, 8'(8'h10 + i), 0);
        cyc(0, 0, 8'h00, 1);
        for (int i = 0; i < 5; i++) cyc(0, 1, 8'(8'h20 + i), 0);
        cyc(0, 1, 8'hEE, 1);
        for (int i = 0; i < 15; i++) cyc(0, 0, 8'h00, 1);
        cyc(0, 0, 8'h00, 0);

        cyc(0, 1, 8'hA5, 1);
        cyc(0, 0, 8'h00, 1);
        cyc(0, 0, 8'h00, 0);

        for (int i = 0; i < 5; i++) cyc(0, 1, 8'(8'h50 + i), 0);
        cyc(0, 0, 8'h00, 1);
        do_reset(0, 1);
        cyc(0, 1, 8'h3C, 0);
        cyc(0, 0, 8'h00, 1);
        cyc(0, 0, 8'h00, 0);

        do_reset(1, 0);
        for (int i = 0; i < 3; i++) cyc(1, 1, 8'(8'h80 + i), 0);
        for (int i = 3; i < 40; i++) cyc(1, 1, 8'(8'h80 + i), 1);
        for (int i = 0; i < 3; i++) cyc(1, 0, 8'h00, 1);
        cyc(1, 0, 8'h00, 0);
        cyc(1, 0, 8'h00, 0);

        for (int i = 0; i < 5; i++) cyc(1, 1, 8'(8'h60 + i), 0);
        cyc(1, 0, 8'h00, 1);
        do_reset(1, 1);
        cyc(1, 1, 8'h3C, 0);
        cyc(1, 0, 8'h00, 1);
        cyc(1, 0, 8'h00, 0);
        cyc(1, 0, 8'h00, 0);

        chk("scoreboard_drained", exq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
